// File: rtl/weight_sink_2.sv
// Coefficient bank loader: fills a MEM_SIZE-entry RAM from a FWFT FIFO and
// holds it for a downstream engine until the engine releases the bank.
module weight_sink_2 #(
  parameter int COEFF_WIDTH = 16,
  parameter int MEM_SIZE    = 9,
  localparam int AW = $clog2(MEM_SIZE),
  localparam int CW = $clog2(MEM_SIZE + 1)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [COEFF_WIDTH-1:0] input_V_dout,
  input  logic                   input_V_empty_n,
  output logic                   input_V_read,
  input  logic                   start,
  input  logic                   bank_release,  // downstream engine is done with the bank
  output logic                   ready,
  input  logic [AW-1:0]          rd_address,
  input  logic                   rd_ce,
  output logic [COEFF_WIDTH-1:0] rd_q,
  output logic [CW-1:0]          load_count
);

  // state   | meaning
  // S_IDLE  | no load in progress, bank not offered downstream
  // S_LOAD  | popping the FIFO into mem[load_count]
  // S_READY | bank complete, waiting for release
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(MEM_SIZE - 1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ready_q, ready_d;
  logic [COEFF_WIDTH-1:0] rd_q_q, rd_q_d;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic                   rd_in_range;

  logic [COEFF_WIDTH-1:0] mem [MEM_SIZE];

  assign input_V_read = (state_q == S_LOAD) && input_V_empty_n;
  assign ready        = ready_q;
  assign load_count   = count_q;
  assign rd_q         = rd_q_q;
  assign wr_addr      = count_q[AW-1:0];
  assign rd_in_range  = int'(rd_address) < MEM_SIZE;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (input_V_empty_n) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          if (count_q == LAST_IDX) begin
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        if (bank_release) begin
          if (start) begin
            state_d = S_LOAD;
            count_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_READY);
  end

  // Out-of-range reads return zero rather than aliasing into the array.
  always_comb begin
    rd_q_d = rd_q_q;
    if (rd_ce) begin
      rd_q_d = rd_in_range ? mem[rd_address] : '0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      rd_q_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= ready_d;
      rd_q_q  <= rd_q_d;
    end
  end

  // Storage is never reset; a same-edge read sees the pre-write contents.
  always_ff @(posedge ap_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= input_V_dout;
    end
  end

endmodule

// File: tb/tb_weight_sink_2.sv
// Bench for weight_sink_2: directed load/stall/reload/reset scenarios followed
// by randomized traffic, all checked against a transaction-level bank model.
module tb_weight_sink_2;

  localparam int CWD = 16;
  localparam int MS  = 9;
  localparam int AW  = $clog2(MS);
  localparam int CW  = $clog2(MS + 1);

  logic           ap_clk = 1'b0;
  logic           ap_rst = 1'b1;
  logic [CWD-1:0] input_V_dout = '0;
  logic           input_V_empty_n = 1'b0;
  logic           input_V_read;
  logic           start = 1'b0;
  logic           bank_release = 1'b0;
  logic           ready;
  logic [AW-1:0]  rd_address = '0;
  logic           rd_ce = 1'b0;
  logic [CWD-1:0] rd_q;
  logic [CW-1:0]  load_count;

  weight_sink_2 #(.COEFF_WIDTH(CWD), .MEM_SIZE(MS)) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .input_V_dout    (input_V_dout),
    .input_V_empty_n (input_V_empty_n),
    .input_V_read    (input_V_read),
    .start           (start),
    .bank_release    (bank_release),
    .ready           (ready),
    .rd_address      (rd_address),
    .rd_ce           (rd_ce),
    .rd_q            (rd_q),
    .load_count      (load_count)
  );

  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: bank contents, load progress and the upstream FIFO.
  logic [CWD-1:0] mem_m [MS];
  bit             mem_known [MS];
  bit             m_loading = 0;
  bit             m_valid = 0;
  int             m_cnt = 0;
  logic [CWD-1:0] m_rdq = '0;
  bit             m_rdq_known = 0;
  logic [CWD-1:0] fifo [$];
  int             gate_mode = 0;
  int             pat_idx = 0;
  int             last_wr_idx = -1;
  int             dut_pops = 0;

  task automatic step();
    bit g;
    int a;
    case (gate_mode)
      0:       g = 1'b1;
      1:       g = ((pat_idx % 3) == 0);
      default: g = 1'($urandom_range(0, 1));
    endcase
    pat_idx++;
    input_V_empty_n = g && (fifo.size() > 0);
    input_V_dout    = (fifo.size() > 0) ? fifo[0] : 16'hDEAD;
    #1;
    check("rd_pulse", {31'd0, input_V_read}, {31'd0, m_loading && input_V_empty_n});
    if (input_V_read && input_V_empty_n) dut_pops++;
    @(posedge ap_clk);
    a = int'(rd_address);
    if (rd_ce) begin
      if (a >= MS) begin
        m_rdq = '0;
        m_rdq_known = 1;
      end else begin
        m_rdq = mem_m[a];
        m_rdq_known = mem_known[a];
      end
    end
    last_wr_idx = -1;
    if (m_loading) begin
      if (input_V_empty_n) begin
        mem_m[m_cnt] = input_V_dout;
        mem_known[m_cnt] = 1;
        last_wr_idx = m_cnt;
        m_cnt++;
        void'(fifo.pop_front());
        if (m_cnt == MS) begin
          m_loading = 0;
          m_valid = 1;
        end
      end
    end else if (m_valid) begin
      if (bank_release) begin
        m_valid = 0;
        if (start) begin
          m_loading = 1;
          m_cnt = 0;
        end
      end
    end else if (start) begin
      m_loading = 1;
      m_cnt = 0;
    end
    #1;
    check("ready", {31'd0, ready}, {31'd0, m_valid});
    check("load_count", 32'(load_count), 32'(m_cnt));
    if (m_rdq_known) check("rd_q", 32'(rd_q), 32'(m_rdq));
    @(negedge ap_clk);
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    #2 ap_rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_read", {31'd0, input_V_read}, 32'd0);
    check("rst_rdq", 32'(rd_q), 32'd0);
    m_loading = 0;
    m_valid = 0;
    m_cnt = 0;
    m_rdq = '0;
    m_rdq_known = 1;
    @(posedge ap_clk);
    #1;
    check("rst_hold_count", 32'(load_count), 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  task automatic push_block(input logic [CWD-1:0] base);
    for (int i = 0; i < MS; i++) fifo.push_back(base + CWD'(i));
  endtask

  task automatic finish_load(input string tag);
    for (int k = 0; k < 200 && m_loading; k++) step();
    check(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < MS; i++) mem_known[i] = 0;
    repeat (2) @(negedge ap_clk);
    #1;
    check("init_ready", {31'd0, ready}, 32'd0);
    check("init_count", 32'(load_count), 32'd0);
    check("init_rdq", 32'(rd_q), 32'd0);
    m_rdq_known = 1;
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // Nothing happens without start, even with data waiting.
    push_block(16'd1);
    repeat (3) step();

    // Continuous load of 1..9.
    gate_mode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    dut_pops = 0;
    repeat (MS) step();
    check("cont_pops", 32'(dut_pops), 32'd9);
    check("cont_ready", {31'd0, ready}, 32'd1);
    check("cont_count", 32'(load_count), 32'd9);
    rd_ce = 1'b1;
    for (int i = 0; i < MS; i++) begin
      rd_address = AW'(i);
      step();
      check("cont_rd", 32'(rd_q), 32'(i + 1));
    end
    rd_ce = 1'b0;

    // Stalled load with empty_n pattern 1,0,0.
    bank_release = 1'b1;
    step();
    bank_release = 1'b0;
    check("rel_idle", {31'd0, ready}, 32'd0);
    push_block(16'h20);
    gate_mode = 1;
    pat_idx = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    finish_load("stall_ready");
    gate_mode = 0;
    rd_ce = 1'b1;
    for (int i = 0; i < MS; i++) begin
      rd_address = AW'(i);
      step();
      check("stall_rd", 32'(rd_q), 32'(16'h20 + i));
    end

    // Reload straight from READY.
    rd_ce = 1'b0;
    push_block(16'h100);
    start = 1'b1;
    bank_release = 1'b1;
    step();
    start = 1'b0;
    bank_release = 1'b0;
    check("reload_drop", {31'd0, ready}, 32'd0);
    finish_load("reload_ready");
    rd_ce = 1'b1;
    rd_address = AW'(4);
    step();
    check("reload_rd4", 32'(rd_q), 32'h104);
    rd_ce = 1'b0;
    rd_address = '0;
    repeat (2) step();
    check("rd_hold", 32'(rd_q), 32'h104);
    rd_ce = 1'b1;
    rd_address = AW'(12);
    step();
    check("rd_oob", 32'(rd_q), 32'd0);

    // Same-edge write and read of address 3.
    rd_address = AW'(3);
    push_block(16'h200);
    start = 1'b1;
    bank_release = 1'b1;
    step();
    start = 1'b0;
    bank_release = 1'b0;
    for (int k = 0; k < 50 && last_wr_idx != 3; k++) step();
    check("rbw_old", 32'(rd_q), 32'h103);
    step();
    check("rbw_new", 32'(rd_q), 32'h203);
    finish_load("rbw_ready");
    rd_ce = 1'b0;

    // Reset after five pops, then a clean reload with start held high.
    bank_release = 1'b1;
    step();
    bank_release = 1'b0;
    push_block(16'h300);
    start = 1'b1;
    step();
    start = 1'b0;
    dut_pops = 0;
    for (int k = 0; k < 50 && dut_pops < 5; k++) step();
    check("mid_pops", 32'(dut_pops), 32'd5);
    do_reset();
    fifo.delete();
    push_block(16'h400);
    start = 1'b1;
    step();
    finish_load("rst_reload_ready");
    start = 1'b0;
    rd_ce = 1'b1;
    for (int i = 0; i < MS; i++) begin
      rd_address = AW'(i);
      step();
    end
    check("rst_reload_rd8", 32'(rd_q), 32'h408);

    // Randomized traffic.
    gate_mode = 2;
    for (int c = 0; c < 600; c++) begin
      if (fifo.size() < 3 && $urandom_range(0, 1) == 1) fifo.push_back(CWD'($urandom));
      start        = ($urandom_range(0, 5) == 0);
      bank_release = ($urandom_range(0, 4) == 0);
      rd_ce        = 1'($urandom_range(0, 1));
      rd_address   = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) do_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_sink_2.md
WEIGHT_SINK_2 -- requirements
Module: weight_sink_2

Interface
REQ-001: Parameter COEFF_WIDTH, default 16, SHALL set the width of one weight coefficient.
REQ-002: Parameter MEM_SIZE, default 9, SHALL set the number of coefficients per load (kernel size); legal range 2..4096.
REQ-003: ap_clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004: ap_rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005: input_V_dout  in  COEFF_WIDTH  SHALL carry the coefficient at the head of the upstream FIFO (first-word-fall-through).
REQ-006: input_V_empty_n  in  1  SHALL indicate, when high, that input_V_dout is valid.
REQ-007: input_V_read  out  1  SHALL pop the upstream FIFO; a word is consumed in every cycle where input_V_read=1 and input_V_empty_n=1.
REQ-008: start  in  1  SHALL request a new load of MEM_SIZE coefficients (level-sampled).
REQ-009: release  in  1  SHALL indicate that the downstream engine has finished with the current bank (level-sampled).
REQ-010: ready  out  1  SHALL indicate that the bank holds a complete, valid set of MEM_SIZE coefficients.
REQ-011: rd_address  in  $clog2(MEM_SIZE)  SHALL select the coefficient to read.
REQ-012: rd_ce  in  1  SHALL enable the read port.
REQ-013: rd_q  out  COEFF_WIDTH  SHALL return the selected coefficient.
REQ-014: load_count  out  $clog2(MEM_SIZE+1)  SHALL report the number of coefficients stored by the current or last load.

Function
REQ-015: The block SHALL implement a three-state FSM: IDLE, LOAD, READY.
REQ-016: In IDLE, start=1 SHALL transition to LOAD on the next edge and clear load_count to 0.
REQ-017: input_V_read SHALL equal (state==LOAD) AND input_V_empty_n; it is combinational and never asserts outside LOAD.
REQ-018: In LOAD, each consumed word SHALL be written to mem[load_count], and load_count SHALL be incremented on the same edge.
REQ-019: In LOAD, input_V_empty_n=0 SHALL stall the load without loss of state; there is no timeout.
REQ-020: When the word consumed has load_count==MEM_SIZE-1, the FSM SHALL enter READY on that edge with load_count=MEM_SIZE.
REQ-021: Upon entering READY, ready SHALL be 1 (registered) in the first cycle of READY; ready SHALL be 0 in IDLE and in LOAD.
REQ-022: In LOAD and READY, start SHALL be ignored, except as specified in REQ-024.
REQ-023: In READY, release=1 with start=0 SHALL transition to IDLE, deasserting ready on the next edge.
REQ-024: In READY, release=1 with start=1 SHALL transition directly to LOAD, clear load_count, and deassert ready.
REQ-025: rd_q SHALL be registered with 1-cycle latency: when rd_ce=1 at edge N, rd_q after edge N equals mem[rd_address]; when rd_ce=0, rd_q holds its value.
REQ-026: An rd_address >= MEM_SIZE with rd_ce=1 SHALL return 0 on rd_q.
REQ-027: The read port SHALL be operable in every state; reads during LOAD return the current memory contents, which may be stale, and the FSM does not gate them.
REQ-028: A write to mem[k] and a read of mem[k] on the same edge SHALL return the old value (read-before-write).
REQ-029: The memory SHALL be inferable as a single simple dual-port RAM with no reset on the storage array.

Reset
REQ-030: While ap_rst=1, the block SHALL be held in IDLE, regardless of the clock, with ready=0, load_count=0, rd_q=0 and input_V_read=0.
REQ-031: Reset asserted mid-LOAD SHALL abandon the load; no word is consumed in the cycle of reset; memory contents are left unchanged.
REQ-032: After ap_rst deasserts, the block SHALL take no action until start=1 is sampled in IDLE.

Verification
REQ-033: Continuous load: reset, start=1 for 1 cycle, FIFO holds 1..9 always non-empty -> exactly 9 read pulses on consecutive cycles, ready=1 on the cycle after the 9th pop, load_count=9, reading addresses 0..8 returns 1..9.
REQ-034: Stalled load: empty_n toggles 1,0,0,1,... -> input_V_read=0 on each empty cycle, stored order preserved, ready only after the 9th accepted word.
REQ-035: Reload in READY: release=1 and start=1 in the same cycle, FIFO supplies 0x100..0x108 -> ready drops for the load duration, then rd_q(addr 4)=0x104.
REQ-036: Reset mid-load: assert ap_rst after 5 pops -> ready=0, load_count=0, input_V_read=0 immediately; a subsequent start reloads cleanly; extra start pulses during LOAD have no effect.
REQ-037: Read port: rd_ce=0 holds rd_q; rd_address=12 with rd_ce=1 -> rd_q=0; a same-edge write and read of address 3 during a reload -> old value returned.
